// File: rtl/execute_cycle_pkg.sv
// Shared RISC-V package: datapath widths, ALU opcodes, forwarding selects,
// the EX/MEM pipeline payload and the forwarding mux helper.
package execute_cycle_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned FWD_W      = 2;

  // ALU operation encodings shared with the decode unit
  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluOpT;

  // Forwarding selects shared with the hazard unit; 2'b11 falls back to the register file
  typedef enum logic [FWD_W-1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwdSelT;

  // EX/MEM pipeline register payload
  typedef struct packed {
    logic                 regWrite;
    logic                 memWrite;
    logic                 resultSrc;
    logic [XLEN-1:0]      aluResult;
    logic [XLEN-1:0]      writeData;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      pcPlus4;
  } exMemT;

  // Operand forwarding mux; any unassigned code selects the register-file value
  function automatic logic [XLEN-1:0] fwdMux(
    input logic [FWD_W-1:0] sel,
    input logic [XLEN-1:0]  regVal,
    input logic [XLEN-1:0]  wbVal,
    input logic [XLEN-1:0]  memVal
  );
    logic [XLEN-1:0] res;
    res = regVal;
    case (sel)
      FWD_WB:  res = wbVal;
      FWD_MEM: res = memVal;
      default: res = regVal;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// Execute-stage ALU: add/sub (mod 2^32), and, or, signed set-less-than.
// Ports: A, B operands; ALU_Control op select; Result; Zero (Result == 0).
// Purely combinational; unassigned opcodes produce 0.
module alu
  import execute_cycle_pkg::*;
(
  input  logic [XLEN-1:0]       A,
  input  logic [XLEN-1:0]       B,
  input  logic [ALU_CTRL_W-1:0] ALU_Control,
  output logic [XLEN-1:0]       Result,
  output logic                  Zero
);

  logic sltBit;

  // Signed compare for SLT
  always_comb begin
    sltBit = ($signed(A) < $signed(B));
  end

  // Operation select; carry and overflow are intentionally dropped
  always_comb begin
    Result = '0;
    case (ALU_Control)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = XLEN'(sltBit);
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// RISC-V execute stage: operand forwarding, ALU, branch decision/target,
// and the EX/MEM pipeline register.
// Inputs : E-stage controls, operands RD1_E/RD2_E, Imm_Ext_E, PCE, PcPlusE,
//          RDE, forwarding selects, ResultW, StallE; clk, rst (async active-low).
// Outputs: PCSrcE/PCTargetE (combinational, not reset-gated);
//          M-stage controls/data (registered, cleared by reset).
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Reg_WriteE,
  input  logic                  Mem_WriteE,
  input  logic                  Result_SrcE,
  input  logic                  BranchE,
  input  logic                  ALU_SrcE,
  input  logic [ALU_CTRL_W-1:0] ALU_ControlE,
  input  logic [XLEN-1:0]       RD1_E,
  input  logic [XLEN-1:0]       RD2_E,
  input  logic [XLEN-1:0]       Imm_Ext_E,
  input  logic [XLEN-1:0]       PCE,
  input  logic [XLEN-1:0]       PcPlusE,
  input  logic [REG_IDX_W-1:0]  RDE,
  input  logic [FWD_W-1:0]      ForwardA_E,
  input  logic [FWD_W-1:0]      ForwardB_E,
  input  logic [XLEN-1:0]       ResultW,
  input  logic                  StallE,
  output logic                  PCSrcE,
  output logic [XLEN-1:0]       PCTargetE,
  output logic                  Reg_WriteM,
  output logic                  Mem_WriteM,
  output logic                  Result_SrcM,
  output logic [XLEN-1:0]       ALU_ResultM,
  output logic [XLEN-1:0]       Write_DataM,
  output logic [XLEN-1:0]       PcPlusM,
  output logic [REG_IDX_W-1:0]  RDM
);

  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] fwdB;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] aluResult;
  logic            aluZero;
  exMemT           exMemQ;
  exMemT           exMemD;

  // Forwarding muxes; the MEM source is the registered result from before this edge
  always_comb begin
    srcA = fwdMux(ForwardA_E, RD1_E, ResultW, exMemQ.aluResult);
    fwdB = fwdMux(ForwardB_E, RD2_E, ResultW, exMemQ.aluResult);
    srcB = ALU_SrcE ? Imm_Ext_E : fwdB;
  end

  alu uAlu (
    .A          (srcA),
    .B          (srcB),
    .ALU_Control(ALU_ControlE),
    .Result     (aluResult),
    .Zero       (aluZero)
  );

  // Branch decision (beq) and target, same cycle
  assign PCSrcE    = BranchE & aluZero;
  assign PCTargetE = PCE + Imm_Ext_E;

  // Next EX/MEM payload; stores carry forwarded B, not the immediate
  always_comb begin
    exMemD           = exMemQ;
    exMemD.regWrite  = Reg_WriteE;
    exMemD.memWrite  = Mem_WriteE;
    exMemD.resultSrc = Result_SrcE;
    exMemD.aluResult = aluResult;
    exMemD.writeData = fwdB;
    exMemD.rd        = RDE;
    exMemD.pcPlus4   = PcPlusE;
  end

  // EX/MEM register; reset discards the in-flight instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exMemQ <= '0;
    end else if (!StallE) begin
      exMemQ <= exMemD;
    end
  end

  assign Reg_WriteM  = exMemQ.regWrite;
  assign Mem_WriteM  = exMemQ.memWrite;
  assign Result_SrcM = exMemQ.resultSrc;
  assign ALU_ResultM = exMemQ.aluResult;
  assign Write_DataM = exMemQ.writeData;
  assign RDM         = exMemQ.rd;
  assign PcPlusM     = exMemQ.pcPlus4;

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits, register index width fixed at 5 bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 Reg_WriteE, Mem_WriteE, Result_SrcE, BranchE, ALU_SrcE  in  1 each  decode-stage control bits for the instruction in EX.
REQ-005 ALU_ControlE  in  3  ALU operation select.
REQ-006 RD1_E, RD2_E  in  32 each  register-file operands A and B.
REQ-007 Imm_Ext_E  in  32  sign-extended immediate.
REQ-008 PCE, PcPlusE  in  32 each  instruction PC and PC+4.
REQ-009 RDE  in  5  destination register index.
REQ-010 ForwardA_E, ForwardB_E  in  2 each  forwarding selects from the hazard unit.
REQ-011 ResultW  in  32  writeback-stage result, used for forwarding.
REQ-012 StallE  in  1  1 = hold the EX/MEM register unchanged this cycle.
REQ-013 PCSrcE  out  1  branch taken, combinational.
REQ-014 PCTargetE  out  32  branch target, combinational.
REQ-015 Reg_WriteM, Mem_WriteM, Result_SrcM  out  1 each  registered controls to the memory stage.
REQ-016 ALU_ResultM, Write_DataM, PcPlusM  out  32 each  registered data to the memory stage.
REQ-017 RDM  out  5  registered destination index.

Function
REQ-018 Operand A SHALL be RD1_E for ForwardA_E=00, ResultW for 01, and ALU_ResultM for 10; code 11 SHALL select RD1_E.
REQ-019 Forwarded B SHALL be selected by ForwardB_E using the same encoding, with RD2_E as the 00/11 source.
REQ-020 ALU operand B SHALL be Imm_Ext_E when ALU_SrcE=1, else forwarded B.
REQ-021 ALU SHALL compute: 000 A+B; 001 A-B; 010 A&B; 011 A|B; 101 signed A<B ? 1 : 0; all other codes 0.
REQ-022 Add and subtract SHALL be modulo 2^32; carry and overflow are discarded.
REQ-023 Zero SHALL be 1 iff the 32-bit ALU result equals 0.
REQ-024 PCSrcE SHALL equal BranchE & Zero (beq semantics), combinationally, in the same cycle.
REQ-025 PCTargetE SHALL equal PCE + Imm_Ext_E modulo 2^32, combinationally.
REQ-026 On a rising edge with StallE=0, the EX/MEM register SHALL load: Reg_WriteE, Mem_WriteE, Result_SrcE, ALU result, forwarded B (into Write_DataM), RDE and PcPlusE. Latency is one cycle.
REQ-027 On a rising edge with StallE=1, every M-side output SHALL hold its previous value.
REQ-028 Write_DataM SHALL carry forwarded B regardless of ALU_SrcE, so that stores use the forwarded value.
REQ-029 Forwarding select 10 SHALL use the registered ALU_ResultM value as it stands before the current edge.
REQ-030 The block SHALL contain no combinational path from any input to any M-side output.

Reset
REQ-031 While rst=0, all M-side outputs SHALL be 0 immediately, independent of clk.
REQ-032 On reset assertion mid-operation, the in-flight instruction SHALL be discarded; Reg_WriteM=0 and Mem_WriteM=0 guarantee no side effect.
REQ-033 The first rising edge after rst returns to 1 SHALL load the EX/MEM register normally.
REQ-034 PCSrcE and PCTargetE are combinational and SHALL NOT be gated by reset.

Structure
REQ-035 ALU opcode constants (ADD, SUB, AND, OR, SLT) and forwarding-select constants SHALL reside in the shared RISC-V package used by the decode and hazard units.
REQ-036 The ALU SHALL be one sub-module, alu (inputs A, B, ALU_Control; outputs Result, Zero); muxes, the target adder and the EX/MEM register stay in execute_cycle.

Verification
REQ-037 Reset: rst=0 asynchronously mid-cycle -> all M outputs read 0 before the next edge; rst=1, ADD 5+7 -> ALU_ResultM=12 one cycle later.
REQ-038 Forwarding: RD1_E=1, ResultW=9, ForwardA_E=01, SUB with B=4 -> ALU_ResultM=5; next cycle ForwardA_E=10, ADD B=1 -> ALU_ResultM=6.
REQ-039 Branch: BranchE=1, A=B=0x10, SUB, PCE=0x100, Imm=0x20 -> PCSrcE=1 and PCTargetE=0x120 in the same cycle; with A!=B -> PCSrcE=0.
REQ-040 Arithmetic edges: 0xFFFFFFFF+1 -> 0 and Zero=1; SLT with A=0xFFFFFFFF (-1), B=1 -> 1; SLT with A=1, B=-1 -> 0; code 111 -> 0.
REQ-041 Stall: load ADD result 3, then hold StallE=1 for two cycles with new inputs -> ALU_ResultM stays 3; release -> new result appears after one edge.
REQ-042 Store path: ALU_SrcE=1, Imm=8, ForwardB_E=01, ResultW=0xDEAD, Mem_WriteE=1 -> Write_DataM=0xDEAD, ALU_ResultM=A+8, Mem_WriteM=1.
